exec_issue: RTL and testbench

- Execute-stage initiator that drives the combinational `alu` and collects its results.
- Accepts decoded ALU operations over a valid/ready handshake and holds each one in an issue register.
- Presents the held operation to an external `alu` instance and captures `rd` and `zero` into a 2-entry result buffer.
- Delivers results to writeback over a second valid/ready handshake. Sits between decode and writeback in the CPU core.

---
 rtl/exec_issue_if.sv | 50 +++++
 rtl/exec_issue.sv | 198 +++++++++++++++++++
 tb/tb_exec_issue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_issue_if.sv
// exec_issue_if: bundles the decode-side handshake, the ALU drive/return
// bus and the writeback-side handshake of the execute issue stage.
// master = surrounding core (decode, alu, writeback); slave = exec_issue.
// XLEN/RIDX must match the parameters of the exec_issue instance.
interface exec_issue_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
);
  // decode -> issue
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_opcode;
  logic            in_s_32;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [RIDX-1:0] in_rs1_idx;
  logic [RIDX-1:0] in_rs2_idx;
  logic [RIDX-1:0] in_rd_idx;
  logic            in_rd_we;
  // issue <-> alu
  logic [4:0]      alu_opcode;
  logic            alu_s_32;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [XLEN-1:0] alu_rd;
  logic            alu_zero;
  // issue -> writeback
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd;
  logic            out_zero;
  logic [RIDX-1:0] out_rd_idx;
  logic            out_rd_we;

  modport slave (
    input  in_valid, in_opcode, in_s_32, in_rs1, in_rs2,
           in_rs1_idx, in_rs2_idx, in_rd_idx, in_rd_we,
           alu_rd, alu_zero, out_ready,
    output in_ready, alu_opcode, alu_s_32, alu_rs1, alu_rs2,
           out_valid, out_rd, out_zero, out_rd_idx, out_rd_we
  );

  modport master (
    output in_valid, in_opcode, in_s_32, in_rs1, in_rs2,
           in_rs1_idx, in_rs2_idx, in_rd_idx, in_rd_we,
           alu_rd, alu_zero, out_ready,
    input  in_ready, alu_opcode, alu_s_32, alu_rs1, alu_rs2,
           out_valid, out_rd, out_zero, out_rd_idx, out_rd_we
  );
endinterface

// File: rtl/exec_issue.sv
// exec_issue: execute-stage initiator. Holds one decoded op in an issue
// register that drives an external combinational alu, and captures the alu
// result into a 2-entry in-order buffer feeding writeback.
// Optional feature macro: EXEC_FWD_EN -- operand forwarding at accept from
// the issue stage and the result buffer (youngest matching result wins).
module exec_issue #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_issue_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic            zero;
    logic [RIDX-1:0] rd_idx;
    logic            rd_we;
  } res_t;

  // issue register
  logic            iss_valid_q,  iss_valid_d;
  logic [4:0]      iss_opcode_q, iss_opcode_d;
  logic            iss_s32_q,    iss_s32_d;
  logic [XLEN-1:0] iss_rs1_q,    iss_rs1_d;
  logic [XLEN-1:0] iss_rs2_q,    iss_rs2_d;
  logic [RIDX-1:0] iss_rd_idx_q, iss_rd_idx_d;
  logic            iss_rd_we_q,  iss_rd_we_d;

  // result buffer: buf0 is always the head, buf1 the younger entry
  res_t            buf0_q, buf0_d;
  res_t            buf1_q, buf1_d;
  logic [1:0]      count_q, count_d;

  logic            advance_s;
  logic            pop_s;
  logic            in_ready_s;
  logic            accept_s;
  res_t            push_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;

  // A full buffer can still take a push when the head leaves this cycle.
  assign advance_s  = iss_valid_q && ((count_q != 2'd2) || bus.out_ready);
  assign pop_s      = (count_q != 2'd0) && bus.out_ready;
  assign in_ready_s = !iss_valid_q || advance_s;
  assign accept_s   = bus.in_valid && in_ready_s;

  assign push_s.rd     = bus.alu_rd;
  assign push_s.zero   = bus.alu_zero;
  assign push_s.rd_idx = iss_rd_idx_q;
  assign push_s.rd_we  = iss_rd_we_q;

`ifdef EXEC_FWD_EN
  logic iss_fv_s;
  logic new_v_s;
  logic old_v_s;
  res_t new_e_s;

  // A candidate result matches a source when it writes that index and the
  // index is not x0 (x0 also marks an immediate on rs2).
  function automatic logic fwd_hit(input logic v, input logic [RIDX-1:0] src,
                                   input logic [RIDX-1:0] idx);
    return v && (src == idx) && (idx != {RIDX{1'b0}});
  endfunction

  assign iss_fv_s = iss_valid_q && iss_rd_we_q;
  assign new_e_s  = (count_q == 2'd2) ? buf1_q : buf0_q;
  assign new_v_s  = (count_q != 2'd0) && new_e_s.rd_we;
  assign old_v_s  = (count_q == 2'd2) && buf0_q.rd_we;

  // Operand select: issue stage, then newest buffer entry, then oldest.
  always_comb begin
    op1_s = bus.in_rs1;
    op2_s = bus.in_rs2;
    if (fwd_hit(iss_fv_s, iss_rd_idx_q, bus.in_rs1_idx)) begin
      op1_s = bus.alu_rd;
    end else if (fwd_hit(new_v_s, new_e_s.rd_idx, bus.in_rs1_idx)) begin
      op1_s = new_e_s.rd;
    end else if (fwd_hit(old_v_s, buf0_q.rd_idx, bus.in_rs1_idx)) begin
      op1_s = buf0_q.rd;
    end else begin
      op1_s = bus.in_rs1;
    end
    if (fwd_hit(iss_fv_s, iss_rd_idx_q, bus.in_rs2_idx)) begin
      op2_s = bus.alu_rd;
    end else if (fwd_hit(new_v_s, new_e_s.rd_idx, bus.in_rs2_idx)) begin
      op2_s = new_e_s.rd;
    end else if (fwd_hit(old_v_s, buf0_q.rd_idx, bus.in_rs2_idx)) begin
      op2_s = buf0_q.rd;
    end else begin
      op2_s = bus.in_rs2;
    end
  end
`else
  logic unused_idx_s;

  assign op1_s        = bus.in_rs1;
  assign op2_s        = bus.in_rs2;
  assign unused_idx_s = ^{bus.in_rs1_idx, bus.in_rs2_idx};
`endif

  // Issue register next state: load on accept, drain when the op advances.
  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_opcode_d = iss_opcode_q;
    iss_s32_d    = iss_s32_q;
    iss_rs1_d    = iss_rs1_q;
    iss_rs2_d    = iss_rs2_q;
    iss_rd_idx_d = iss_rd_idx_q;
    iss_rd_we_d  = iss_rd_we_q;
    if (accept_s) begin
      iss_valid_d  = 1'b1;
      iss_opcode_d = bus.in_opcode;
      iss_s32_d    = bus.in_s_32;
      iss_rs1_d    = op1_s;
      iss_rs2_d    = op2_s;
      iss_rd_idx_d = bus.in_rd_idx;
      iss_rd_we_d  = bus.in_rd_we;
    end else if (advance_s) begin
      iss_valid_d  = 1'b0;
    end else begin
      iss_valid_d  = iss_valid_q;
    end
  end

  // Result buffer next state: shift-style FIFO with head kept in buf0.
  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    case ({advance_s, pop_s})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          buf0_d = push_s;
        end else begin
          buf1_d = push_s;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        buf0_d  = buf1_q;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = push_s;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers; reset discards any op or result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= 5'd0;
      iss_s32_q    <= 1'b0;
      iss_rs1_q    <= {XLEN{1'b0}};
      iss_rs2_q    <= {XLEN{1'b0}};
      iss_rd_idx_q <= {RIDX{1'b0}};
      iss_rd_we_q  <= 1'b0;
      buf0_q       <= {$bits(res_t){1'b0}};
      buf1_q       <= {$bits(res_t){1'b0}};
      count_q      <= 2'd0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_opcode_q <= iss_opcode_d;
      iss_s32_q    <= iss_s32_d;
      iss_rs1_q    <= iss_rs1_d;
      iss_rs2_q    <= iss_rs2_d;
      iss_rd_idx_q <= iss_rd_idx_d;
      iss_rd_we_q  <= iss_rd_we_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.alu_opcode = iss_valid_q ? iss_opcode_q : 5'd0;
  assign bus.alu_s_32   = iss_valid_q && iss_s32_q;
  assign bus.alu_rs1    = iss_valid_q ? iss_rs1_q : {XLEN{1'b0}};
  assign bus.alu_rs2    = iss_valid_q ? iss_rs2_q : {XLEN{1'b0}};
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.out_rd     = buf0_q.rd;
  assign bus.out_zero   = buf0_q.zero;
  assign bus.out_rd_idx = buf0_q.rd_idx;
  assign bus.out_rd_we  = buf0_q.rd_we;

endmodule

// File: tb/tb_exec_issue.sv
// tb_exec_issue: directed self-checking bench for exec_issue with a small
// behavioural alu model. Inputs change on the falling edge; outputs are
// checked 1ns after the falling edge, well away from the rising edge.
module tb_exec_issue;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_SLT = 5'd2;
  localparam logic [4:0] ALU_XOR = 5'd4;

  logic clk;
  logic rst_n;
  int   vec;
  int   miss;

  exec_issue_if #(.XLEN(32), .RIDX(5)) bus ();

  exec_issue #(.XLEN(32), .RIDX(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu model
  always_comb begin
    case (bus.alu_opcode)
      ALU_ADD: bus.alu_rd = bus.alu_rs1 + bus.alu_rs2;
      ALU_SUB: bus.alu_rd = bus.alu_rs1 - bus.alu_rs2;
      ALU_SLT: bus.alu_rd = {31'd0, ($signed(bus.alu_rs1) < $signed(bus.alu_rs2))};
      ALU_XOR: bus.alu_rd = bus.alu_rs1 ^ bus.alu_rs2;
      default: bus.alu_rd = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_rd == 32'd0);
  end

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ai, input logic [4:0] bi,
                       input logic [4:0] di, input logic we);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_s_32 = 1'b0;
    bus.in_rs1 = a; bus.in_rs2 = b; bus.in_rs1_idx = ai; bus.in_rs2_idx = bi;
    bus.in_rd_idx = di; bus.in_rd_we = we;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_opcode = 5'd0; bus.in_s_32 = 1'b0;
    bus.in_rs1 = 32'd0; bus.in_rs2 = 32'd0; bus.in_rs1_idx = 5'd0;
    bus.in_rs2_idx = 5'd0; bus.in_rd_idx = 5'd0; bus.in_rd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); bus.out_ready = 1'b0;
    #1;
    vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    vec++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    vec++; if ({bus.out_rd, bus.out_zero, bus.out_rd_idx, bus.out_rd_we} !== 39'd0) begin
      miss++; $display("FAIL reset_out_fields: got rd=%0h z=%0b idx=%0d we=%0b want 0", bus.out_rd, bus.out_zero, bus.out_rd_idx, bus.out_rd_we); end
    vec++; if ({bus.alu_opcode, bus.alu_s_32, bus.alu_rs1, bus.alu_rs2} !== 70'd0) begin
      miss++; $display("FAIL reset_alu_fields: got op=%0d rs1=%0h rs2=%0h want 0", bus.alu_opcode, bus.alu_rs1, bus.alu_rs2); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(ALU_ADD, 32'd5, 32'd7, 5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL add_in_ready: got %0b want 1", bus.in_ready); end
    @(negedge clk); idle(); #1;
    vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL add_no_passthru: got %0b want 0", bus.out_valid); end
    vec++; if (bus.alu_rs1 !== 32'd5 || bus.alu_rs2 !== 32'd7) begin
      miss++; $display("FAIL add_alu_ops: got %0h,%0h want 5,7", bus.alu_rs1, bus.alu_rs2); end
    @(negedge clk); #1;
    vec++; if (bus.out_valid !== 1'b1) begin miss++; $display("FAIL add_out_valid: got %0b want 1", bus.out_valid); end
    vec++; if (bus.out_rd !== 32'd12 || bus.out_zero !== 1'b0) begin
      miss++; $display("FAIL add_result: got %0d z=%0b want 12 z=0", bus.out_rd, bus.out_zero); end
    vec++; if (bus.out_rd_idx !== 5'd9 || bus.out_rd_we !== 1'b1) begin
      miss++; $display("FAIL add_dest: got idx=%0d we=%0b want 9 1", bus.out_rd_idx, bus.out_rd_we); end
    vec++; if (bus.alu_opcode !== 5'd0 || bus.alu_rs1 !== 32'd0) begin
      miss++; $display("FAIL add_alu_idle: got op=%0d rs1=%0h want 0", bus.alu_opcode, bus.alu_rs1); end
    @(negedge clk); #1;
    vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL add_drained: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [3];
    logic        exp_z  [3];
    exp_rd[0] = 32'd0;    exp_z[0] = 1'b1;
    exp_rd[1] = 32'hFF;   exp_z[1] = 1'b0;
    exp_rd[2] = 32'd1;    exp_z[2] = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) drive(ALU_SUB, 32'd3, 32'd3, 5'd0, 5'd0, 5'd3, 1'b1);
      else if (j == 1) drive(ALU_XOR, 32'hF0, 32'h0F, 5'd0, 5'd0, 5'd4, 1'b1);
      else if (j == 2) drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0, 5'd5, 1'b1);
      else idle();
      #1;
      if (j >= 2 && j <= 4) begin
        vec++; if (bus.out_valid !== 1'b1 || bus.out_rd !== exp_rd[j-2] || bus.out_zero !== exp_z[j-2] || bus.out_rd_idx !== 5'(j+1)) begin
          miss++; $display("FAIL b2b_result%0d: got v=%0b rd=%0h z=%0b idx=%0d want v=1 rd=%0h z=%0b idx=%0d",
                           j-2, bus.out_valid, bus.out_rd, bus.out_zero, bus.out_rd_idx, exp_rd[j-2], exp_z[j-2], j+1); end
      end else if (j == 5) begin
        vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL b2b_drained: got %0b want 0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'd100; exp_rd[1] = 32'd102; exp_rd[2] = 32'd104; exp_rd[3] = 32'd106;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      bus.out_ready = (j >= 5);
      if (j <= 2) drive(ALU_ADD, 32'(100 + j), 32'(j), 5'd0, 5'd0, 5'(j + 1), 1'b1);
      else if (j <= 5) drive(ALU_ADD, 32'd103, 32'd3, 5'd0, 5'd0, 5'd4, 1'b1);
      else idle();
      #1;
      if (j <= 2) begin
        vec++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL bp_ready%0d: got %0b want 1", j, bus.in_ready); end
      end else if (j <= 4) begin
        vec++; if (bus.in_ready !== 1'b0 || bus.alu_rs1 !== 32'd102 || bus.out_rd !== exp_rd[0]) begin
          miss++; $display("FAIL bp_stall%0d: got rdy=%0b alu_rs1=%0d out=%0d want 0 102 100", j, bus.in_ready, bus.alu_rs1, bus.out_rd); end
      end else if (j == 5) begin
        vec++; if (bus.in_ready !== 1'b1 || bus.out_rd !== exp_rd[0] || bus.out_valid !== 1'b1) begin
          miss++; $display("FAIL bp_release: got rdy=%0b v=%0b out=%0d want 1 1 100", bus.in_ready, bus.out_valid, bus.out_rd); end
      end else if (j <= 8) begin
        vec++; if (bus.out_valid !== 1'b1 || bus.out_rd !== exp_rd[j-5] || bus.out_rd_idx !== 5'(j - 4)) begin
          miss++; $display("FAIL bp_drain%0d: got v=%0b rd=%0d idx=%0d want 1 %0d %0d", j-5, bus.out_valid, bus.out_rd, bus.out_rd_idx, exp_rd[j-5], j-4); end
      end else begin
        vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL bp_empty: got %0b want 0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      bus.out_ready = (j >= 3);
      if (j < 7) drive(ALU_ADD, 32'd200, 32'(j), 5'd0, 5'd0, 5'(j + 10), 1'b1);
      else idle();
      #1;
      if (j < 7) begin
        vec++; if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL full_ready%0d: got %0b want 1", j, bus.in_ready); end
      end
      if (j >= 3 && j < 10) begin
        vec++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 32'(200 + j - 3) || bus.out_rd_idx !== 5'(j + 7)) begin
          miss++; $display("FAIL full_out%0d: got v=%0b rd=%0d idx=%0d want 1 %0d %0d", j-3, bus.out_valid, bus.out_rd, bus.out_rd_idx, 200+j-3, j+7); end
      end else if (j == 10) begin
        vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL full_empty: got %0b want 0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(ALU_ADD, 32'd1, 32'(j), 5'd0, 5'd0, 5'd1, 1'b1);
    end
    @(negedge clk); idle(); #1;
    vec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      miss++; $display("FAIL rst_mid_full: got v=%0b rdy=%0b want 1 0", bus.out_valid, bus.in_ready); end
    rst_n = 1'b0; #1;
    vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_rd !== 32'd0 || bus.alu_rs1 !== 32'd0) begin
      miss++; $display("FAIL rst_mid_async: got v=%0b rdy=%0b rd=%0h alu_rs1=%0h want 0 1 0 0", bus.out_valid, bus.in_ready, bus.out_rd, bus.alu_rs1); end
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      vec++; if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL rst_mid_after%0d: got %0b want 0", j, bus.out_valid); end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a;
    logic [31:0] exp_c;
`ifdef EXEC_FWD_EN
    exp_a = 32'd31; exp_c = 32'd11;
`else
    exp_a = 32'd1;  exp_c = 32'd1;
`endif
    // from issue stage, then with rd_idx=0 (never forwarded)
    for (int k = 0; k < 2; k++) begin
      bus.out_ready = 1'b1;
      @(negedge clk); drive(ALU_ADD, 32'd10, 32'd20, 5'd0, 5'd0, (k == 0) ? 5'd1 : 5'd0, 1'b1);
      @(negedge clk); drive(ALU_ADD, 32'd0, 32'd1, (k == 0) ? 5'd1 : 5'd0, 5'd0, 5'd2, 1'b1);
      @(negedge clk); idle(); #1;
      vec++; if (bus.out_rd !== 32'd30) begin miss++; $display("FAIL fwd_first%0d: got %0d want 30", k, bus.out_rd); end
      @(negedge clk); #1;
      vec++; if (bus.out_valid !== 1'b1 || bus.out_rd !== ((k == 0) ? exp_a : 32'd1)) begin
        miss++; $display("FAIL fwd_second%0d: got v=%0b rd=%0d want 1 %0d", k, bus.out_valid, bus.out_rd, (k == 0) ? exp_a : 32'd1); end
    end
    // from the result buffer, rs2 slot, while writeback is stalled
    @(negedge clk); bus.out_ready = 1'b0; drive(ALU_ADD, 32'd5, 32'd5, 5'd0, 5'd0, 5'd3, 1'b1);
    @(negedge clk); idle();
    @(negedge clk); drive(ALU_ADD, 32'd1, 32'd0, 5'd0, 5'd3, 5'd4, 1'b1);
    @(negedge clk); idle(); bus.out_ready = 1'b1; #1;
    vec++; if (bus.out_rd !== 32'd10) begin miss++; $display("FAIL fwd_buf_first: got %0d want 10", bus.out_rd); end
    @(negedge clk); #1;
    vec++; if (bus.out_valid !== 1'b1 || bus.out_rd !== exp_c) begin
      miss++; $display("FAIL fwd_buf_second: got v=%0b rd=%0d want 1 %0d", bus.out_valid, bus.out_rd, exp_c); end
    @(negedge clk);
  endtask

  initial begin
    vec = 0; miss = 0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_reset_midstream();
    test_forwarding();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000ns");
    $fatal(1);
  end
endmodule
